// File: rtl/mem_access_pkg.sv
// ----------------------------------------------------------------------------
// mem_access_pkg
//   Shared defaults and types for the memory access controller and its
//   response FIFO.
//   Contents:
//     MEM_ADDR_W / MEM_DATA_W / MEM_LATENCY / MEM_RSP_DEPTH : default widths,
//                                        read latency and response depth
//     mem_req_t  : one request beat (write enable, address, write data)
//     mem_rsp_t  : one read response beat
//     cnt_width  : width of a counter able to hold 0..depth inclusive
// ----------------------------------------------------------------------------
package mem_access_pkg;

   localparam int MEM_ADDR_W    = 2;
   localparam int MEM_DATA_W    = 5;
   localparam int MEM_LATENCY   = 2;
   localparam int MEM_RSP_DEPTH = 4;

   typedef struct packed {
      logic                  we;
      logic [MEM_ADDR_W-1:0] addr;
      logic [MEM_DATA_W-1:0] wdata;
   } mem_req_t;

   typedef struct packed {
      logic [MEM_DATA_W-1:0] data;
   } mem_rsp_t;

   // A counter that must represent both "empty" and "full" needs one more
   // code point than the depth itself.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/mem_rsp_fifo.sv
// ----------------------------------------------------------------------------
// mem_rsp_fifo
//   Synchronous FIFO buffering read responses. Output data comes straight
//   from storage, so it is registered and stable while not popped.
//   Ports:
//     CLK          in   clock, all state on posedge
//     RESET        in   synchronous active-high reset (empties the FIFO)
//     push_i       in   write push_data_i into the tail
//     push_data_i  in   data to store
//     pop_i        in   remove the head entry (ignored when empty)
//     pop_data_o   out  head entry, don't-care when valid_o=0
//     valid_o      out  FIFO holds at least one entry
//     count_o      out  number of stored entries, 0..DEPTH
// ----------------------------------------------------------------------------
module mem_rsp_fifo
   import mem_access_pkg::*;
#(
   parameter int DEPTH  = MEM_RSP_DEPTH,
   parameter int DATA_W = MEM_DATA_W
) (
   input  logic                        CLK,
   input  logic                        RESET,
   input  logic                        push_i,
   input  logic [DATA_W-1:0]           push_data_i,
   input  logic                        pop_i,
   output logic [DATA_W-1:0]           pop_data_o,
   output logic                        valid_o,
   output logic [cnt_width(DEPTH)-1:0] count_o
);

   localparam int CNT_W = cnt_width(DEPTH);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wptr_q, wptr_d;
   logic [PTR_W-1:0]  rptr_q, rptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              pop;

   // Pointers wrap modulo DEPTH, which need not be a power of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(DEPTH - 1)) return '0;
      return p + PTR_W'(1);
   endfunction

   assign pop        = pop_i & (count_q != '0);
   assign valid_o    = (count_q != '0);
   assign count_o    = count_q;
   assign pop_data_o = mem_q[rptr_q];

   always_comb begin
      // NOTE: every signal assigned in this block gets a default first, so no
      // path leaves it unassigned and no latch is inferred.
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (push_i) wptr_d = ptr_inc(wptr_q);
      if (pop)    rptr_d = ptr_inc(rptr_q);
      unique case ({push_i, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;   // idle, or push and pop cancel out
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of the others, independent of block order.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // NOTE: the storage array has no reset; count_q alone decides which
   // entries are meaningful, and leaving the array unreset keeps it mappable
   // to plain RAM or flop arrays without reset fan-out.
   always_ff @(posedge CLK) begin
      if (push_i) mem_q[wptr_q] <= push_data_i;
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// ----------------------------------------------------------------------------
// mem_access_ctrl
//   Initiator-side controller for a fixed-latency Memory (sync-read array plus
//   output register). Takes one valid/ready request stream (reads and
//   writes), drives the Memory ports, and returns read data in order on a
//   valid/ready response stream. Reads are only issued while a response slot
//   is guaranteed, so backpressure never drops data.
//   Ports:
//     CLK, RESET            clock; synchronous active-high reset
//     req_valid/req_ready   request handshake (fire = valid & ready)
//     req_we                1 = write, 0 = read
//     req_addr, req_wdata   request address / write data
//     rsp_valid/rsp_ready   response handshake (pop = valid & ready)
//     rsp_data              read data, in request order
//     idle                  nothing in flight and no buffered responses
//     RADDR, WADDR, WDATA,  Memory port drive
//     WE
//     RDATA                 Memory read data, LATENCY cycles after RADDR
// ----------------------------------------------------------------------------
module mem_access_ctrl
   import mem_access_pkg::*;
#(
   parameter int ADDR_W    = MEM_ADDR_W,
   parameter int DATA_W    = MEM_DATA_W,
   parameter int LATENCY   = MEM_LATENCY,
   parameter int RSP_DEPTH = MEM_RSP_DEPTH
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              idle,
   output logic [ADDR_W-1:0] RADDR,
   output logic [ADDR_W-1:0] WADDR,
   output logic [DATA_W-1:0] WDATA,
   output logic              WE,
   input  logic [DATA_W-1:0] RDATA
);

   localparam int CNT_W = cnt_width(RSP_DEPTH);

   // Every read in flight must already own a FIFO slot, so the FIFO has to
   // cover at least the full memory pipeline.
   if (RSP_DEPTH < LATENCY) begin : g_depth_check
      $error("mem_access_ctrl: RSP_DEPTH must be >= LATENCY");
   end

   logic [LATENCY-1:0] inflight_q, inflight_d;
   logic [CNT_W-1:0]   inflight_cnt;
   logic [CNT_W-1:0]   fifo_count;
   logic [CNT_W-1:0]   credits;
   logic               req_fire;
   logic               rd_fire;
   logic               rsp_pop;

   // Memory ports are pure pass-through; the handshake only gates WE.
   assign RADDR = req_addr;
   assign WADDR = req_addr;
   assign WDATA = req_wdata;

   assign req_fire = req_valid & req_ready;
   assign rd_fire  = req_fire & ~req_we;
   assign WE       = req_fire & req_we & ~RESET;

   // Credits are derived from registered state only: a pop this cycle frees
   // its slot next cycle, keeping rsp_ready off the req_ready path.
   always_comb begin
      inflight_cnt = '0;
      for (int i = 0; i < LATENCY; i++) begin
         inflight_cnt = inflight_cnt + CNT_W'(inflight_q[i]);
      end
   end

   assign credits   = CNT_W'(RSP_DEPTH) - fifo_count - inflight_cnt;
   assign req_ready = ~RESET & (credits != '0);
   assign idle      = (inflight_q == '0) & (fifo_count == '0);

   // One bit per memory pipeline stage; the last stage marks RDATA valid.
   always_comb begin
      inflight_d[0] = rd_fire;
      for (int i = 1; i < LATENCY; i++) begin
         inflight_d[i] = inflight_q[i-1];
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) inflight_q <= '0;
      else       inflight_q <= inflight_d;
   end

   assign rsp_pop = rsp_valid & rsp_ready;

   mem_rsp_fifo #(
      .DEPTH  (RSP_DEPTH),
      .DATA_W (DATA_W)
   ) u_rsp_fifo (
      .CLK         (CLK),
      .RESET       (RESET),
      .push_i      (inflight_q[LATENCY-1]),
      .push_data_i (RDATA),
      .pop_i       (rsp_pop),
      .pop_data_o  (rsp_data),
      .valid_o     (rsp_valid),
      .count_o     (fifo_count)
   );

endmodule

// File: tb/tb_mem_access_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mem_access_ctrl
//   Bench for mem_access_ctrl driving a 2-cycle-latency Memory model.
//   A transaction-level model (reference memory plus a queue of expected
//   responses with their earliest visible cycle) is compared against the DUT
//   on every falling edge; directed sequences add literal expectations.
// ----------------------------------------------------------------------------
module tb_mem_access_ctrl;
   import mem_access_pkg::*;

   localparam int ADDR_W    = 2;
   localparam int DATA_W    = 5;
   localparam int LATENCY   = 2;
   localparam int RSP_DEPTH = 4;

   logic              CLK = 1'b0;
   logic              RESET;
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_data;
   logic              idle;
   logic [ADDR_W-1:0] RADDR;
   logic [ADDR_W-1:0] WADDR;
   logic [DATA_W-1:0] WDATA;
   logic              WE;
   logic [DATA_W-1:0] RDATA;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;
   int edge_n = 0;

   always #5 CLK = ~CLK;

   mem_access_ctrl #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .LATENCY   (LATENCY),
      .RSP_DEPTH (RSP_DEPTH)
   ) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .idle      (idle),
      .RADDR     (RADDR),
      .WADDR     (WADDR),
      .WDATA     (WDATA),
      .WE        (WE),
      .RDATA     (RDATA)
   );

   // Memory: synchronous read array followed by an output register.
   logic [DATA_W-1:0] mem [1 << ADDR_W];
   logic [DATA_W-1:0] mem_rd_q;
   always @(posedge CLK) begin
      if (WE) mem[WADDR] <= WDATA;
      mem_rd_q <= mem[RADDR];
      RDATA    <= mem_rd_q;
   end

   // ---------------- reference model ----------------
   typedef struct {
      mem_rsp_t rsp;
      int       avail;   // first edge after which this response is visible
   } exp_t;

   logic [DATA_W-1:0] ref_mem [1 << ADDR_W];
   exp_t              exp_q [$];
   logic [DATA_W-1:0] got [$];
   int                got_edge [$];

   always @(posedge CLK) begin
      bit   rdy;
      exp_t e;
      rdy = !RESET && (exp_q.size() < RSP_DEPTH);
      if (RESET) begin
         exp_q.delete();
      end else if (exp_q.size() > 0 && exp_q[0].avail <= edge_n && rsp_ready) begin
         void'(exp_q.pop_front());
      end
      edge_n++;
      if (req_valid && rdy) begin
         if (req_we) begin
            ref_mem[req_addr] = req_wdata;
         end else begin
            e.rsp.data = ref_mem[req_addr];
            e.avail    = edge_n + LATENCY;
            exp_q.push_back(e);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model.
   always @(negedge CLK) begin
      bit m_ready;
      bit m_valid;
      if (chk_en) begin
         m_ready = !RESET && (exp_q.size() < RSP_DEPTH);
         m_valid = (exp_q.size() > 0) && (exp_q[0].avail <= edge_n);
         check("req_ready", req_ready, m_ready);
         check("rsp_valid", rsp_valid, m_valid);
         check("idle", idle, exp_q.size() == 0);
         check("WE", WE, req_valid & m_ready & req_we);
         check("RADDR", RADDR, req_addr);
         check("WDATA", WDATA, req_wdata);
         if (m_valid) check("rsp_data", rsp_data, exp_q[0].rsp.data);
         total++;
         assert (!(dut.u_rsp_fifo.push_i && dut.u_rsp_fifo.count_q == RSP_DEPTH))
         else begin
            bad++;
            $display("FAIL fifo_push_full: push into full FIFO (t=%0t)", $time);
         end
         if (rsp_valid && rsp_ready) begin
            got.push_back(rsp_data);
            got_edge.push_back(edge_n);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   function automatic mem_req_t mk(input logic we, input logic [ADDR_W-1:0] a,
                                   input logic [DATA_W-1:0] d);
      mem_req_t r;
      r.we    = we;
      r.addr  = a;
      r.wdata = d;
      return r;
   endfunction

   function automatic logic [31:0] got_at(input int i);
      if (i < got.size()) return 32'(got[i]);
      return 'x;
   endfunction

   // Holds the request until accepted; fire_edge is the edge that took it.
   task automatic issue(input mem_req_t r, output int fire_edge);
      int n;
      n = 0;
      req_valid = 1'b1;
      req_we    = r.we;
      req_addr  = r.addr;
      req_wdata = r.wdata;
      while (!req_ready && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) begin
         total++;
         bad++;
         $display("FAIL issue_timeout: request not accepted within 50 cycles");
      end
      fire_edge = edge_n + 1;
      tick();
      req_valid = 1'b0;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int e;
      int n_acc;
      RESET     = 1'b1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      rsp_ready = 1'b1;

      // Reset state.
      tick();
      chk_en = 1'b1;
      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_idle", idle, 1);
      check("rst_WE", WE, 0);
      tick();
      RESET = 1'b0;
      #1;
      check("post_rst_ready", req_ready, 1);

      // 1. Write then read same address on the next cycle.
      got.delete(); got_edge.delete();
      issue(mk(1'b1, 2'd1, 5'h15), e);
      issue(mk(1'b0, 2'd1, 5'h00), e);
      check("t1_valid_fire+0", rsp_valid, 0);
      tick();
      check("t1_valid_fire+1", rsp_valid, 0);
      tick();
      check("t1_valid_fire+2", rsp_valid, 1);
      check("t1_data", rsp_data, 5'h15);
      repeat (2) tick();
      check("t1_count", got.size(), 1);

      // 2. Fill memory, then back-to-back reads with rsp_ready high.
      for (int i = 0; i < 4; i++) issue(mk(1'b1, 2'(i), 5'(i + 1)), e);
      got.delete(); got_edge.delete();
      for (int i = 0; i < 4; i++) begin
         check("t2_ready", req_ready, 1);
         issue(mk(1'b0, 2'(i), 5'h00), e);
      end
      repeat (4) tick();
      check("t2_count", got.size(), 4);
      for (int i = 0; i < 4; i++) check("t2_data", got_at(i), i + 1);
      if (got_edge.size() == 4) check("t2_consecutive", got_edge[3] - got_edge[0], 3);

      // 3. Backpressure: 6 reads offered, only 4 credits.
      got.delete(); got_edge.delete();
      rsp_ready = 1'b0;
      n_acc = 0;
      req_valid = 1'b1;
      req_we    = 1'b0;
      for (int i = 0; i < 6; i++) begin
         req_addr = 2'(i % 4);
         if (req_ready) n_acc++;
         tick();
      end
      req_valid = 1'b0;
      check("t3_accepted", n_acc, 4);
      check("t3_ready_low", req_ready, 0);
      rsp_ready = 1'b1;
      repeat (8) tick();
      check("t3_count", got.size(), 4);
      for (int i = 0; i < 4; i++) check("t3_data", got_at(i), i + 1);
      check("t3_ready_back", req_ready, 1);

      // 4. Reset with reads in flight and responses buffered.
      got.delete(); got_edge.delete();
      rsp_ready = 1'b0;
      for (int i = 0; i < 4; i++) issue(mk(1'b0, 2'(i), 5'h00), e);
      check("t4_busy", idle, 0);
      check("t4_buffered", dut.u_rsp_fifo.count_q, 2);
      RESET = 1'b1;
      #1;
      check("t4_ready_in_rst", req_ready, 0);
      tick();
      RESET = 1'b0;
      #1;
      check("t4_rsp_valid", rsp_valid, 0);
      check("t4_idle", idle, 1);
      rsp_ready = 1'b1;
      repeat (6) tick();
      check("t4_no_stale", got.size(), 0);
      issue(mk(1'b0, 2'd2, 5'h00), e);
      repeat (4) tick();
      check("t4_reread_count", got.size(), 1);
      check("t4_reread_data", got_at(0), 5'h03);

      // 5. Push and pop in the same cycle with three entries buffered.
      got.delete(); got_edge.delete();
      rsp_ready = 1'b0;
      for (int i = 0; i < 4; i++) issue(mk(1'b0, 2'(i), 5'h00), e);
      tick();
      check("t5_count_before", dut.u_rsp_fifo.count_q, 3);
      rsp_ready = 1'b1;
      tick();
      check("t5_count_after", dut.u_rsp_fifo.count_q, 3);
      repeat (5) tick();
      check("t5_count", got.size(), 4);
      for (int i = 0; i < 4; i++) check("t5_data", got_at(i), i + 1);
      check("t5_idle", idle, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
